lv_trace_reader: RTL and testbench
==================================

Name: lv_trace_reader

Overview:
- Clocked read-side companion to the spike-clocked last-value register. That register is written on spike edges, asynchronously to the system clock.
- On request, this block takes a stable snapshot of the last-value timestamp and computes elapsed time against the current timestamp.
- It returns a decayed trace value through a valid/ready response channel.
- Sits between the per-neuron last-value storage and the clocked neuron/layer logic that consumes event traces.

Parameters:
p_width, 21, width of timestamps and last-value
p_trace_width, 8, width of output trace; trace max = 2^p_trace_width-1
p_window_log2, 10, linear decay window = 2^p_window_log2 ticks
p_shift_log2, 7, ticks per halving in shift-decay mode (optional feature only)
p_max_retry, 3, max snapshot re-samples before error response

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous active-high reset
i_req_valid  input  1  read request
o_req_ready  output  1  request accepted when valid&ready
i_lv  input  p_width  last-value timestamp from spike-clocked register (asynchronous domain)
i_lv_valid  input  1  last-value has been written at least once since reset
i_time  input  p_width  current timestamp, synchronous to i_clk
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed when valid&ready
o_rsp_trace  output  p_trace_width  decayed trace
o_rsp_elapsed  output  p_width  elapsed ticks (saturated)
o_rsp_err  output  1  snapshot never stabilised

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_trace=0, o_rsp_elapsed=0, o_rsp_err=0, retry count=0.
- Reset asserted mid-operation aborts immediately; any pending response is dropped.
- States:
  - IDLE: o_req_ready=1. On i_req_valid, latch i_time into t_req, sample i_lv/i_lv_valid into snapshot A, go to SAMPLE.
  - SAMPLE: o_req_ready=0. Sample i_lv/i_lv_valid into snapshot B.
    - If A==B (value and valid bit): go to CALC.
    - Else: A<=B, retry count+1, stay in SAMPLE.
    - If retry count reaches p_max_retry with a mismatch: go to RESP with o_rsp_err=1, trace=0, elapsed=all ones.
  - CALC: elapsed = (t_req - A) modulo 2^p_width, so timestamp wrap-around is handled by unsigned subtract. Compute trace, register outputs, go to RESP.
  - RESP: o_rsp_valid=1, outputs held stable until i_rsp_ready. On handshake: o_rsp_valid=0, retry count=0, go to IDLE.
- No new request is accepted while in RESP; one request is in flight at a time.
- Trace (linear, default):
  - If snapshot valid bit=0: trace=0, elapsed=all ones.
  - Else if elapsed >= 2^p_window_log2: trace=0.
  - Else trace = min(2^p_trace_width-1, ((2^p_window_log2 - elapsed) << p_trace_width) >> p_window_log2).
  - Intermediate width is p_width+p_trace_width+1; no overflow is allowed.
- Latency with a stable snapshot: request handshake in cycle 0, o_rsp_valid high in cycle 3. Each retry adds 1 cycle.
- i_req_valid deasserting after acceptance has no effect.

Optional Feature:
- Macro: LV_TRACE_READER_SHIFT_DECAY_EN.
- Defined: trace = (2^p_trace_width-1) >> (elapsed >> p_shift_log2). Trace is 0 when the shift amount >= p_trace_width. The window rule is not applied. Valid-bit and error rules are unchanged.
- Undefined: linear decay as above. p_shift_log2 is unused.

Test Plan:
- Reset, then request with i_lv_valid=0, i_time=500 -> o_rsp_valid in cycle 3; trace=0; elapsed=0x1FFFFF; err=0.
- i_lv=1000, valid=1, i_time=1512, defaults, linear -> elapsed=512, trace=128. With i_time=1000 -> elapsed=0, trace=255 (saturated).
- Wrap: i_lv=0x1FFF00, i_time=0x000100 -> elapsed=0x200=512, trace=128. With i_time=i_lv+1024 -> trace=0.
- Snapshot toggles each cycle for 5 cycles -> err=1, trace=0, after 3 retries (response in cycle 6). Toggling once then stable -> err=0, response in cycle 4.
- Hold i_rsp_ready=0 for 10 cycles -> outputs stable, o_req_ready=0, a new i_req_valid is ignored. Assert i_rst during SAMPLE -> o_rsp_valid=0, o_req_ready=1 immediately.
- With LV_TRACE_READER_SHIFT_DECAY_EN defined: elapsed=0 -> 255; elapsed=128 -> 127; elapsed=300 -> 63; elapsed=1024 -> 0.

Source files
------------

// File: rtl/lv_trace_reader.sv
// lv_trace_reader
//
// Clocked read side of the spike-clocked last-value register. A request
// captures the current timestamp. The block then takes a stable snapshot of
// the asynchronously written last-value by sampling it repeatedly until two
// consecutive samples agree. It computes the elapsed ticks and a decayed
// trace, and returns them on a valid/ready response channel.
//
// Optional feature:
//   LV_TRACE_READER_SHIFT_DECAY_EN - when defined, the trace halves every
//   2^p_shift_log2 ticks. When undefined, the trace decays linearly to zero
//   over a window of 2^p_window_log2 ticks.
//
// Ports:
//   i_clk, i_rst             system clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake
//   i_lv, i_lv_valid         last-value and its written flag (async domain)
//   i_time                   current timestamp (i_clk domain)
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_trace              decayed trace
//   o_rsp_elapsed            elapsed ticks, all ones when invalid or error
//   o_rsp_err                snapshot never stabilised

module lv_trace_reader #(
    parameter int unsigned p_width       = 21,
    parameter int unsigned p_trace_width = 8,
    parameter int unsigned p_window_log2 = 10,
`ifdef LV_TRACE_READER_SHIFT_DECAY_EN
    parameter int unsigned p_shift_log2  = 7,
`endif
    parameter int unsigned p_max_retry   = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [p_width-1:0]       i_lv,
    input  logic                     i_lv_valid,
    input  logic [p_width-1:0]       i_time,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [p_trace_width-1:0] o_rsp_trace,
    output logic [p_width-1:0]       o_rsp_elapsed,
    output logic                     o_rsp_err
);

    localparam int unsigned lp_retry_w = $clog2(p_max_retry + 1);

    typedef enum logic [1:0] {StIdle, StSample, StCalc, StResp} state_e;

    state_e                  state_q;
    logic [p_width-1:0]      t_req_q;
    logic [p_width-1:0]      snap_lv_q;
    logic                    snap_v_q;
    logic [lp_retry_w-1:0]   retry_q;
    logic                    err_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [p_trace_width-1:0] rsp_trace_q;
    logic [p_width-1:0]      rsp_elapsed_q;
    logic                    rsp_err_q;

    // Unsigned subtract handles timestamp wrap-around.
    logic [p_width-1:0]       elapsed;
    logic [p_trace_width-1:0] trace_calc;

    assign elapsed = t_req_q - snap_lv_q;

`ifdef LV_TRACE_READER_SHIFT_DECAY_EN
    localparam logic [p_trace_width-1:0] lp_trace_max = '1;

    logic [p_width-1:0] shamt;

    always_comb begin
        shamt      = elapsed >> p_shift_log2;
        trace_calc = '0;
        if (shamt < p_width'(p_trace_width)) begin
            trace_calc = lp_trace_max >> shamt;
        end
    end
`else
    localparam int unsigned lp_calc_w = p_width + p_trace_width + 1;
    localparam logic [lp_calc_w-1:0] lp_window    = lp_calc_w'(1) << p_window_log2;
    localparam logic [lp_calc_w-1:0] lp_trace_max = (lp_calc_w'(1) << p_trace_width) - 1;

    logic [lp_calc_w-1:0] remain;
    logic [lp_calc_w-1:0] scaled;

    always_comb begin
        remain     = '0;
        scaled     = '0;
        trace_calc = '0;
        if (lp_calc_w'(elapsed) < lp_window) begin
            remain = lp_window - lp_calc_w'(elapsed);
            scaled = (remain << p_trace_width) >> p_window_log2;
            // Only elapsed == 0 can exceed the max, which saturates to the max.
            if (scaled > lp_trace_max) begin
                trace_calc = lp_trace_max[p_trace_width-1:0];
            end else begin
                trace_calc = scaled[p_trace_width-1:0];
            end
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            t_req_q       <= '0;
            snap_lv_q     <= '0;
            snap_v_q      <= 1'b0;
            retry_q       <= '0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_trace_q   <= '0;
            rsp_elapsed_q <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req_valid) begin
                        t_req_q     <= i_time;
                        snap_lv_q   <= i_lv;
                        snap_v_q    <= i_lv_valid;
                        req_ready_q <= 1'b0;
                        state_q     <= StSample;
                    end
                end
                StSample: begin
                    // Two matching samples mean no spike write was in flight.
                    if ({i_lv_valid, i_lv} == {snap_v_q, snap_lv_q}) begin
                        state_q <= StCalc;
                    end else if (retry_q == lp_retry_w'(p_max_retry)) begin
                        // Error also passes through StCalc, so each retry costs one cycle.
                        err_q   <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        snap_lv_q <= i_lv;
                        snap_v_q  <= i_lv_valid;
                        retry_q   <= retry_q + lp_retry_w'(1);
                    end
                end
                StCalc: begin
                    if (err_q) begin
                        rsp_err_q     <= 1'b1;
                        rsp_trace_q   <= '0;
                        rsp_elapsed_q <= '1;
                    end else if (!snap_v_q) begin
                        rsp_err_q     <= 1'b0;
                        rsp_trace_q   <= '0;
                        rsp_elapsed_q <= '1;
                    end else begin
                        rsp_err_q     <= 1'b0;
                        rsp_trace_q   <= trace_calc;
                        rsp_elapsed_q <= elapsed;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        retry_q     <= '0;
                        err_q       <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_trace   = rsp_trace_q;
    assign o_rsp_elapsed = rsp_elapsed_q;
    assign o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_lv_trace_reader.sv
// Directed bench for lv_trace_reader with default parameters. Expected trace
// values are chosen per decay mode via LV_TRACE_READER_SHIFT_DECAY_EN.

module tb_lv_trace_reader;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [20:0] i_lv;
    logic        i_lv_valid;
    logic [20:0] i_time;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [7:0]  o_rsp_trace;
    logic [20:0] o_rsp_elapsed;
    logic        o_rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 i_clk = ~i_clk;

    lv_trace_reader dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_lv         (i_lv),
        .i_lv_valid   (i_lv_valid),
        .i_time       (i_time),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_trace  (o_rsp_trace),
        .o_rsp_elapsed(o_rsp_elapsed),
        .o_rsp_err    (o_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Issues one request; for edges 1..tog after
    // acceptance, i_lv alternates lv^1, lv, ... then holds. lat is the
    // cycle (handshake = cycle 0) in which o_rsp_valid is first seen, -1 if never.
    task automatic do_req(input logic [20:0] lv, input logic v, input logic [20:0] t,
                          input int tog, output int lat_o);
        i_lv        = lv;
        i_lv_valid  = v;
        i_time      = t;
        i_req_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        lat_o = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k <= tog) i_lv = lv ^ ((k % 2 == 1) ? 21'd1 : 21'd0);
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_rsp_valid) begin
                lat_o = k + 1;
                break;
            end
        end
    endtask

    task automatic consume();
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    task automatic req_check(input string tag, input logic [20:0] lv, input logic [20:0] t,
                             input logic [20:0] exp_el, input logic [7:0] exp_tr);
        do_req(lv, 1'b1, t, 0, lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_elapsed"}, o_rsp_elapsed, exp_el);
        check({tag, "_trace"}, o_rsp_trace, exp_tr);
        check({tag, "_err"}, o_rsp_err, 0);
        consume();
    endtask

`ifdef LV_TRACE_READER_SHIFT_DECAY_EN
    localparam logic [7:0] e512 = 8'd15;
    localparam logic [7:0] e128 = 8'd127;
    localparam logic [7:0] e300 = 8'd63;
    localparam logic [7:0] e599 = 8'd15;
    localparam logic [7:0] e100 = 8'd255;
`else
    localparam logic [7:0] e512 = 8'd128;
    localparam logic [7:0] e128 = 8'd224;
    localparam logic [7:0] e300 = 8'd181;
    localparam logic [7:0] e599 = 8'd106;
    localparam logic [7:0] e100 = 8'd231;
`endif

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_lv        = '0;
        i_lv_valid  = 1'b0;
        i_time      = '0;
        i_rsp_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_req_ready", o_req_ready, 1);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_trace", o_rsp_trace, 0);
        check("rst_elapsed", o_rsp_elapsed, 0);
        check("rst_err", o_rsp_err, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Never-written last-value.
        do_req(21'd0, 1'b0, 21'd500, 0, lat);
        check("inv_lat", lat, 3);
        check("inv_trace", o_rsp_trace, 0);
        check("inv_elapsed", o_rsp_elapsed, 21'h1FFFFF);
        check("inv_err", o_rsp_err, 0);
        check("inv_req_ready", o_req_ready, 0);
        consume();
        check("inv_back_idle", o_req_ready, 1);
        check("inv_valid_drop", o_rsp_valid, 0);

        req_check("e512", 21'd1000, 21'd1512, 21'd512, e512);
        req_check("e0", 21'd1000, 21'd1000, 21'd0, 8'd255);
        req_check("e128", 21'd1000, 21'd1128, 21'd128, e128);
        req_check("e300", 21'd1000, 21'd1300, 21'd300, e300);
        req_check("e1024", 21'd1000, 21'd2024, 21'd1024, 8'd0);
        req_check("wrap512", 21'h1FFF00, 21'h000100, 21'h200, e512);
        req_check("wrap1024", 21'h1FFF00, 21'h000300, 21'h400, 8'd0);

        // Unstable snapshot: retries exhausted.
        do_req(21'd1000, 1'b1, 21'd1512, 5, lat);
        check("err_lat", lat, 6);
        check("err_err", o_rsp_err, 1);
        check("err_trace", o_rsp_trace, 0);
        check("err_elapsed", o_rsp_elapsed, 21'h1FFFFF);
        consume();

        // One toggle then stable: snapshot settles on 1001.
        do_req(21'd1000, 1'b1, 21'd1600, 1, lat);
        check("tog1_lat", lat, 4);
        check("tog1_err", o_rsp_err, 0);
        check("tog1_elapsed", o_rsp_elapsed, 21'd599);
        check("tog1_trace", o_rsp_trace, e599);
        consume();

        // Backpressure: outputs held, new request ignored.
        do_req(21'd1000, 1'b1, 21'd1100, 0, lat);
        check("hold_lat", lat, 3);
        i_req_valid = 1'b1;
        i_time      = 21'd5000;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("hold_valid", o_rsp_valid, 1);
            check("hold_req_ready", o_req_ready, 0);
            check("hold_trace", o_rsp_trace, e100);
            check("hold_elapsed", o_rsp_elapsed, 21'd100);
        end
        i_req_valid = 1'b0;
        consume();
        check("hold_release_valid", o_rsp_valid, 0);
        check("hold_release_ready", o_req_ready, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("hold_no_ghost_req", o_req_ready, 1);

        // Reset in SAMPLE aborts immediately.
        i_lv        = 21'd1000;
        i_lv_valid  = 1'b1;
        i_time      = 21'd1512;
        i_req_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("abort_in_sample", o_req_ready, 0);
        i_rst = 1'b1;
        #1;
        check("abort_valid", o_rsp_valid, 0);
        check("abort_req_ready", o_req_ready, 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("abort_still_idle", o_rsp_valid, 0);

        req_check("post_abort", 21'd1000, 21'd1512, 21'd512, e512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
